// File: rtl/alu_issue_if.sv
// Bus bundle between the issue sequencer and its environment: instruction
// handshake, register-file read/write ports and the ALU control/data lines.
interface alu_issue_if;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        alu_enable;
    logic [2:0]  alu_funct3;
    logic [6:0]  alu_funct7;
    logic [31:0] alu_operand_0;
    logic [31:0] alu_operand_1;
    logic [31:0] alu_result;
    logic        rd_we;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic        illegal;
    logic        busy;

    // The environment: fetch, register file and ALU.
    modport master (
        output instr_valid, instr, rs1_data, rs2_data, alu_result,
        input  instr_ready, rs1_addr, rs2_addr, alu_enable, alu_funct3, alu_funct7,
               alu_operand_0, alu_operand_1, rd_we, rd_addr, rd_data, illegal, busy
    );

    // The issue sequencer itself.
    modport slave (
        input  instr_valid, instr, rs1_data, rs2_data, alu_result,
        output instr_ready, rs1_addr, rs2_addr, alu_enable, alu_funct3, alu_funct7,
               alu_operand_0, alu_operand_1, rd_we, rd_addr, rd_data, illegal, busy
    );
endinterface

// File: rtl/alu_issue.sv
// Issue/writeback sequencer: decodes one RV32I OP/OP-IMM instruction, reads
// its operands, drives the clocked ALU for ALU_LATENCY cycles and writes rd.
module alu_issue #(
    parameter int unsigned ALU_LATENCY = 1
) (
    input  logic        clock,
    input  logic        reset_n,
    alu_issue_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

    localparam logic [3:0] LAT_M1 = 4'(ALU_LATENCY - 1);

    state_t      state;
    state_t      state_next;
    logic [31:0] instr_q;
    logic [31:0] operand_0_q;
    logic [31:0] operand_1_q;
    logic [31:0] rd_data_q;
    logic [2:0]  funct3_q;
    logic [6:0]  funct7_q;
    logic [3:0]  count_q;

    logic        dec_illegal;
    logic        dec_use_imm;
    logic [6:0]  dec_funct7;
    logic [31:0] dec_imm;

    // Shift immediates pass instr[31:25] through; every other OP-IMM forces
    // funct7 to zero so a negative ADDI immediate can never select SUB.
    always_comb begin
        dec_illegal = 1'b0;
        dec_use_imm = 1'b0;
        dec_funct7  = 7'h00;
        dec_imm     = {{20{instr_q[31]}}, instr_q[31:20]};
        case (instr_q[6:0])
            7'b0110011: begin
                dec_funct7  = instr_q[31:25];
                dec_illegal = (instr_q[31:25] != 7'h00) && (instr_q[31:25] != 7'h20);
            end
            7'b0010011: begin
                dec_use_imm = 1'b1;
                if (instr_q[14:12] == 3'b001) begin
                    dec_funct7  = instr_q[31:25];
                    dec_illegal = (instr_q[31:25] != 7'h00);
                end else if (instr_q[14:12] == 3'b101) begin
                    dec_funct7  = instr_q[31:25];
                    dec_illegal = (instr_q[31:25] != 7'h00) && (instr_q[31:25] != 7'h20);
                end
            end
            default: dec_illegal = 1'b1;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next      = state;
        bus.instr_ready = 1'b0;
        bus.busy        = 1'b1;
        bus.alu_enable  = 1'b0;
        bus.illegal     = 1'b0;
        bus.rd_we       = 1'b0;
        case (state)
            IDLE: begin
                bus.instr_ready = 1'b1;
                bus.busy        = 1'b0;
                if (bus.instr_valid) state_next = READ;
            end
            READ: begin
                bus.illegal = dec_illegal;
                state_next  = dec_illegal ? IDLE : EXEC;
            end
            EXEC: begin
                bus.alu_enable = 1'b1;
                if (count_q == 4'd0) state_next = WB;
            end
            WB: begin
                bus.rd_we  = (instr_q[11:7] != 5'd0);
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Operands and ALU controls are only updated by a legal READ, so they
    // keep their last values through IDLE, WB and rejected instructions.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            instr_q     <= 32'd0;
            operand_0_q <= 32'd0;
            operand_1_q <= 32'd0;
            rd_data_q   <= 32'd0;
            funct3_q    <= 3'd0;
            funct7_q    <= 7'd0;
            count_q     <= 4'd0;
        end else begin
            case (state)
                IDLE: if (bus.instr_valid) instr_q <= bus.instr;
                READ: if (!dec_illegal) begin
                    operand_0_q <= bus.rs1_data;
                    operand_1_q <= dec_use_imm ? dec_imm : bus.rs2_data;
                    funct3_q    <= instr_q[14:12];
                    funct7_q    <= dec_funct7;
                    count_q     <= LAT_M1;
                end
                EXEC: begin
                    if (count_q == 4'd0) rd_data_q <= bus.alu_result;
                    else                 count_q   <= count_q - 4'd1;
                end
                default: ;
            endcase
        end
    end

    assign bus.rs1_addr      = instr_q[19:15];
    assign bus.rs2_addr      = instr_q[24:20];
    assign bus.rd_addr       = instr_q[11:7];
    assign bus.rd_data       = rd_data_q;
    assign bus.alu_funct3    = funct3_q;
    assign bus.alu_funct7    = funct7_q;
    assign bus.alu_operand_0 = operand_0_q;
    assign bus.alu_operand_1 = operand_1_q;

endmodule
